// File: rtl/collision_event_handler.sv
// Collision event handler: latches per-pixel collision levels once per frame and turns them into
// single-cycle game events, score deltas, frightened-mode timing and the death hold.
module collision_event_handler #(
    parameter int FRIGHT_FRAMES  = 360,
    parameter int WARN_FRAMES    = 120,
    parameter int DEATH_FRAMES   = 90,
    parameter int EDOT_PTS       = 10,
    parameter int PDOT_PTS       = 50,
    parameter int GHOST_BASE_PTS = 200
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        pm_rg_col,
    input  logic        pm_pg_col,
    input  logic        pm_cg_col,
    input  logic        pm_og_col,
    input  logic        pm_pdot_col,
    input  logic        pm_edot_col,
    output logic        score_valid,
    output logic [11:0] score_delta,
    output logic        edot_eaten,
    output logic        pdot_eaten,
    output logic [3:0]  ghost_eaten,
    output logic        frightened,
    output logic        fright_warn,
    output logic        pm_death,
    output logic        respawn
);

    localparam int FCW = $clog2(FRIGHT_FRAMES + 1);
    localparam int DCW = $clog2(DEATH_FRAMES + 1);
    localparam logic [11:0] EDOT_P  = 12'(EDOT_PTS);
    localparam logic [11:0] PDOT_P  = 12'(PDOT_PTS);
    localparam logic [11:0] GHOST_P = 12'(GHOST_BASE_PTS);

    typedef enum logic [1:0] {ST_NORMAL, ST_FRIGHT, ST_DEATH} state_t;

    state_t           state, state_nx;
    logic [FCW-1:0]   fright_cnt, fright_cnt_nx;
    logic [DCW-1:0]   death_cnt, death_cnt_nx;
    logic [1:0]       chain, chain_nx;
    logic [3:0]       eaten_mask, eaten_mask_nx;

    logic [3:0]       ghost_col, ghost_flag;
    logic             edot_flag, pdot_flag;
    logic [11:0]      dot_pts;

    logic [11:0]      delta_nx;
    logic [3:0]       ghost_nx;
    logic             edot_nx, pdot_nx, death_nx, respawn_nx;

    assign ghost_col = {pm_og_col, pm_cg_col, pm_pg_col, pm_rg_col};
    assign dot_pts   = (edot_flag ? EDOT_P : 12'd0) + (pdot_flag ? PDOT_P : 12'd0);

    // Sticky flags: the startOfFrame cycle's own inputs belong to the new frame only.
    always_ff @(posedge clk or negedge resetN) begin
        // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!resetN) begin
            ghost_flag <= '0;
            edot_flag  <= 1'b0;
            pdot_flag  <= 1'b0;
        end else if (startOfFrame) begin
            ghost_flag <= ghost_col;
            edot_flag  <= pm_edot_col;
            pdot_flag  <= pm_pdot_col;
        end else begin
            ghost_flag <= ghost_flag | ghost_col;
            edot_flag  <= edot_flag | pm_edot_col;
            pdot_flag  <= pdot_flag | pm_pdot_col;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_nx      = state;
        fright_cnt_nx = fright_cnt;
        death_cnt_nx  = death_cnt;
        chain_nx      = chain;
        eaten_mask_nx = eaten_mask;
        delta_nx      = '0;
        ghost_nx      = '0;
        edot_nx       = 1'b0;
        pdot_nx       = 1'b0;
        death_nx      = 1'b0;
        respawn_nx    = 1'b0;

        if (startOfFrame) begin
            case (state)
                ST_NORMAL: begin
                    edot_nx  = edot_flag;
                    pdot_nx  = pdot_flag;
                    delta_nx = dot_pts;
                    if (|ghost_flag) begin
                        death_nx     = 1'b1;
                        state_nx     = ST_DEATH;
                        death_cnt_nx = DCW'(DEATH_FRAMES);
                    end else if (pdot_flag) begin
                        state_nx      = ST_FRIGHT;
                        fright_cnt_nx = FCW'(FRIGHT_FRAMES);
                        chain_nx      = '0;
                        eaten_mask_nx = '0;
                    end
                end
                ST_FRIGHT: begin
                    edot_nx  = edot_flag;
                    pdot_nx  = pdot_flag;
                    delta_nx = dot_pts;
                    // Chain order R, P, C, O follows the bit order of ghost_flag.
                    for (int i = 0; i < 4; i++) begin
                        if (ghost_flag[i] && !eaten_mask_nx[i]) begin
                            ghost_nx[i]      = 1'b1;
                            eaten_mask_nx[i] = 1'b1;
                            delta_nx         = delta_nx + (GHOST_P << chain_nx);
                            if (chain_nx != 2'd3) chain_nx = chain_nx + 2'd1;
                        end
                    end
                    if (pdot_flag) begin
                        fright_cnt_nx = FCW'(FRIGHT_FRAMES);
                        chain_nx      = '0;
                        eaten_mask_nx = '0;
                    end else if (fright_cnt <= FCW'(1)) begin
                        state_nx      = ST_NORMAL;
                        fright_cnt_nx = '0;
                        chain_nx      = '0;
                        eaten_mask_nx = '0;
                    end else begin
                        fright_cnt_nx = fright_cnt - FCW'(1);
                    end
                end
                ST_DEATH: begin
                    if (death_cnt <= DCW'(1)) begin
                        respawn_nx   = 1'b1;
                        state_nx     = ST_NORMAL;
                        death_cnt_nx = '0;
                    end else begin
                        death_cnt_nx = death_cnt - DCW'(1);
                    end
                end
                default: state_nx = ST_NORMAL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= ST_NORMAL;
            fright_cnt  <= '0;
            death_cnt   <= '0;
            chain       <= '0;
            eaten_mask  <= '0;
            score_valid <= 1'b0;
            score_delta <= '0;
            edot_eaten  <= 1'b0;
            pdot_eaten  <= 1'b0;
            ghost_eaten <= '0;
            pm_death    <= 1'b0;
            respawn     <= 1'b0;
        end else begin
            state       <= state_nx;
            fright_cnt  <= fright_cnt_nx;
            death_cnt   <= death_cnt_nx;
            chain       <= chain_nx;
            eaten_mask  <= eaten_mask_nx;
            score_valid <= (delta_nx != 12'd0);
            score_delta <= delta_nx;
            edot_eaten  <= edot_nx;
            pdot_eaten  <= pdot_nx;
            ghost_eaten <= ghost_nx;
            pm_death    <= death_nx;
            respawn     <= respawn_nx;
        end
    end

    assign frightened  = (state == ST_FRIGHT);
    assign fright_warn = frightened && (fright_cnt <= FCW'(WARN_FRAMES));

endmodule

// File: tb/tb_collision_event_handler.sv
// Self-checking bench for collision_event_handler: frame vectors feed a scoreboard of expected
// pulse records, compared on the cycle after each startOfFrame; level outputs checked inline.
module tb_collision_event_handler;

    localparam logic [5:0] C_R  = 6'b000001;
    localparam logic [5:0] C_P  = 6'b000010;
    localparam logic [5:0] C_C  = 6'b000100;
    localparam logic [5:0] C_O  = 6'b001000;
    localparam logic [5:0] C_PD = 6'b010000;
    localparam logic [5:0] C_ED = 6'b100000;

    typedef struct {
        logic [5:0]  col;    // {edot, pdot, O, C, P, R}
        int          cyc;
        logic [11:0] delta;
        logic        e;
        logic        p;
        logic [3:0]  g;
        logic        death;
        logic        resp;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic [5:0]  col_bus = '0;
    logic        score_valid, edot_eaten, pdot_eaten, frightened, fright_warn, pm_death, respawn;
    logic [11:0] score_delta;
    logic [3:0]  ghost_eaten;

    int   errors = 0;
    int   checks = 0;
    vec_t sb[$];
    logic tick_prev = 1'b0;

    collision_event_handler dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .pm_rg_col    (col_bus[0]),
        .pm_pg_col    (col_bus[1]),
        .pm_cg_col    (col_bus[2]),
        .pm_og_col    (col_bus[3]),
        .pm_pdot_col  (col_bus[4]),
        .pm_edot_col  (col_bus[5]),
        .score_valid  (score_valid),
        .score_delta  (score_delta),
        .edot_eaten   (edot_eaten),
        .pdot_eaten   (pdot_eaten),
        .ghost_eaten  (ghost_eaten),
        .frightened   (frightened),
        .fright_warn  (fright_warn),
        .pm_death     (pm_death),
        .respawn      (respawn)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] col, input int cyc, input logic [11:0] d,
                                input logic e, input logic p, input logic [3:0] g,
                                input logic death, input logic resp);
        vec_t v;
        v.col = col; v.cyc = cyc; v.delta = d; v.e = e; v.p = p;
        v.g = g; v.death = death; v.resp = resp;
        return v;
    endfunction

    function automatic logic [20:0] pack(input vec_t v);
        return {v.delta, (v.delta != 12'd0), v.e, v.p, v.g, v.death, v.resp};
    endfunction

    // Pulse monitor: expects the queued record on the cycle after a tick, all pulses low otherwise.
    always @(posedge clk) tick_prev <= startOfFrame;

    always @(negedge clk) begin
        logic [20:0] exp_v;
        logic [20:0] act_v;
        exp_v = '0;
        act_v = {score_delta, score_valid, edot_eaten, pdot_eaten, ghost_eaten, pm_death, respawn};
        if (tick_prev) begin
            check("sb_underflow", 32'(sb.size() == 0), 32'd0);
            if (sb.size() != 0) exp_v = pack(sb.pop_front());
        end
        check("pulses", 32'(act_v), 32'(exp_v));
    end

    // Holds col for cyc cycles, then one startOfFrame cycle carrying sof_col.
    task automatic frame(input logic [5:0] col, input int cyc, input logic [5:0] sof_col,
                         input vec_t exp);
        col_bus = col;
        repeat (cyc) @(posedge clk);
        #1;
        col_bus      = sof_col;
        startOfFrame = 1'b1;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        startOfFrame = 1'b0;
        col_bus      = '0;
    endtask

    task automatic quiet(input logic [5:0] col, input vec_t exp);
        frame(col, 1, 6'b0, exp);
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[13];
        vec_t zero;
        zero = mk(6'b0, 1, 12'd0, 0, 0, 4'b0000, 0, 0);

        tbl[0]  = mk(C_ED,            5, 12'd10,   1, 0, 4'b0000, 0, 0);
        tbl[1]  = mk(6'b0,            1, 12'd0,    0, 0, 4'b0000, 0, 0);
        tbl[2]  = mk(C_PD,            2, 12'd50,   0, 1, 4'b0000, 0, 0);
        tbl[3]  = mk(C_R | C_C,       3, 12'd600,  0, 0, 4'b0101, 0, 0);
        tbl[4]  = mk(C_P | C_ED,      2, 12'd810,  1, 0, 4'b0010, 0, 0);
        tbl[5]  = mk(C_R,             2, 12'd0,    0, 0, 4'b0000, 0, 0);
        tbl[6]  = mk(C_O,             1, 12'd1600, 0, 0, 4'b1000, 0, 0);
        tbl[7]  = mk(C_R|C_P|C_C|C_O, 2, 12'd0,    0, 0, 4'b0000, 0, 0);
        tbl[8]  = mk(C_PD,            1, 12'd50,   0, 1, 4'b0000, 0, 0);
        tbl[9]  = mk(C_C,             1, 12'd200,  0, 0, 4'b0100, 0, 0);
        tbl[10] = mk(C_R|C_P|C_PD,    2, 12'd1250, 0, 1, 4'b0011, 0, 0);
        tbl[11] = mk(C_C,             1, 12'd200,  0, 0, 4'b0100, 0, 0);
        tbl[12] = mk(C_C,             1, 12'd0,    0, 0, 4'b0000, 0, 0);

        // Reset state
        @(posedge clk);
        #1;
        check("reset_outputs",
              32'({score_delta, score_valid, edot_eaten, pdot_eaten, ghost_eaten,
                   pm_death, respawn, frightened, fright_warn}), 32'd0);
        resetN = 1'b1;
        @(posedge clk);
        #1;

        // Dots, ghost chain, re-eaten ghosts, power-dot reload
        for (int i = 0; i < 13; i++) begin
            frame(tbl[i].col, tbl[i].cyc, 6'b0, tbl[i]);
            if (i >= 2) check("tbl_frightened", 32'(frightened), 32'd1);
        end
        @(negedge clk);

        // Frightened timer and warning window
        do_reset();
        quiet(C_PD, mk(6'b0, 1, 12'd50, 0, 1, 4'b0000, 0, 0));
        check("fright_start", 32'({frightened, fright_warn}), 32'b10);
        for (int k = 1; k <= 360; k++) begin
            logic exp_fr, exp_w;
            quiet(6'b0, zero);
            exp_fr = (k < 360);
            exp_w  = exp_fr && ((360 - k) <= 120);
            check("fright_lvl", 32'({frightened, fright_warn}), 32'({exp_fr, exp_w}));
        end

        // Death with a dot in the same frame, then the hold
        quiet(C_P | C_ED, mk(6'b0, 1, 12'd10, 1, 0, 4'b0000, 1, 0));
        check("death_no_fright", 32'(frightened), 32'd0);
        for (int k = 1; k < 90; k++) quiet(6'b111111, zero);
        check("death_hold_fright", 32'(frightened), 32'd0);
        quiet(6'b111111, mk(6'b0, 1, 12'd0, 0, 0, 4'b0000, 0, 1));
        quiet(C_ED, mk(6'b0, 1, 12'd10, 1, 0, 4'b0000, 0, 0));

        // Collision exactly on startOfFrame lands in the next frame
        frame(6'b0, 1, C_ED, zero);
        quiet(6'b0, mk(6'b0, 1, 12'd10, 1, 0, 4'b0000, 0, 0));

        // Reset in the middle of DEATH, with a pending dot flag
        quiet(C_R, mk(6'b0, 1, 12'd0, 0, 0, 4'b0000, 1, 0));
        for (int k = 0; k < 3; k++) quiet(6'b0, zero);
        col_bus = C_ED;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetN  = 1'b0;
        col_bus = '0;
        #1;
        check("midreset_outputs",
              32'({score_delta, score_valid, edot_eaten, pdot_eaten, ghost_eaten,
                   pm_death, respawn, frightened, fright_warn}), 32'd0);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        @(posedge clk);
        #1;
        quiet(6'b0, zero);
        quiet(C_PD, mk(6'b0, 1, 12'd50, 0, 1, 4'b0000, 0, 0));
        check("post_reset_fright", 32'(frightened), 32'd1);
        quiet(C_R, mk(6'b0, 1, 12'd200, 0, 0, 4'b0001, 0, 0));

        repeat (2) @(negedge clk);
        check("sb_leftover", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
